// File: rtl/game_pkg.sv
// Shared types and defaults for the match sequencer and the compositor it feeds.
package game_pkg;

   localparam int HP_WIDTH            = 3;
   localparam int HP_INIT             = 5;
   localparam int START_HOLD_FRAMES   = 120;
   localparam int RESULT_HOLD_FRAMES  = 180;
   localparam int HIT_COOLDOWN_FRAMES = 30;

   typedef enum logic [1:0] {
      PHASE_IDLE   = 2'd0,
      PHASE_START  = 2'd1,
      PHASE_PLAY   = 2'd2,
      PHASE_RESULT = 2'd3
   } GamePhase;

   typedef enum logic [3:0] {
      OBJECT_MAP           = 4'd0,
      OBJECT_IDLE_BG       = 4'd1,
      OBJECT_START_BG      = 4'd2,
      OBJECT_START_CAPTION = 4'd3,
      OBJECT_WIN_CAPTION   = 4'd4,
      OBJECT_LOSE_CAPTION  = 4'd5
   } ObjectID;

endpackage

// File: rtl/game_flow_ctrl_hp_tracker.sv
// One player's HP register with hit cooldown; hp_next exposes the value being
// written this edge so the sequencer can react to a lethal hit on the same edge.
import game_pkg::*;

module hp_tracker #(
   parameter int HP_INIT_VAL   = HP_INIT,
   parameter int COOLDOWN_FRMS = HIT_COOLDOWN_FRAMES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic                en,
   input  logic                hit,
   input  logic                shield,
   input  logic                frame_tick,
   output logic [HP_WIDTH-1:0] hp,
   output logic [HP_WIDTH-1:0] hp_next
);

   localparam int CW = (COOLDOWN_FRMS > 0) ? $clog2(COOLDOWN_FRMS + 1) : 1;

   logic [HP_WIDTH-1:0] hp_q, hp_d;
   logic [CW-1:0]       cool_q, cool_d;
   logic                accept;

   assign accept = en && hit && !shield && (cool_q == '0);

   always_comb begin
      hp_d   = hp_q;
      cool_d = cool_q;
      if (load) begin
         hp_d   = HP_WIDTH'(HP_INIT_VAL);
         cool_d = '0;
      end else if (accept) begin
         // A freshly loaded cooldown is not ticked down on the edge it loads.
         if (hp_q != '0) hp_d = hp_q - 1'b1;
         cool_d = CW'(COOLDOWN_FRMS);
      end else if (frame_tick && (cool_q != '0)) begin
         cool_d = cool_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hp_q   <= HP_WIDTH'(HP_INIT_VAL);
         cool_q <= '0;
      end else begin
         hp_q   <= hp_d;
         cool_q <= cool_d;
      end
   end

   assign hp      = hp_q;
   assign hp_next = hp_d;

endmodule

// File: rtl/game_flow_ctrl.sv
// Match phase sequencer: IDLE/START/PLAY/RESULT, HP tracking and render select.
import game_pkg::*;

module game_flow_ctrl #(
   parameter int START_HOLD_FRAMES   = game_pkg::START_HOLD_FRAMES,
   parameter int RESULT_HOLD_FRAMES  = game_pkg::RESULT_HOLD_FRAMES,
   parameter int HP_INIT             = game_pkg::HP_INIT,
   parameter int HIT_COOLDOWN_FRAMES = game_pkg::HIT_COOLDOWN_FRAMES
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_frame_tick,
   input  logic                i_start_btn,
   input  logic                i_p1_hit,
   input  logic                i_p2_hit,
   input  logic                i_p1_shield,
   input  logic                i_p2_shield,
   output logic [1:0]          o_phase,
   output logic [HP_WIDTH-1:0] o_p1_hp,
   output logic [HP_WIDTH-1:0] o_p2_hp,
   output logic [1:0]          o_winner,
   output logic                o_play_en,
   output logic                o_round_reset,
   output logic [3:0]          o_bg_object,
   output logic [3:0]          o_caption_object,
   output logic                o_caption_valid
);

   localparam int MAX_HOLD = (START_HOLD_FRAMES > RESULT_HOLD_FRAMES) ?
                             START_HOLD_FRAMES : RESULT_HOLD_FRAMES;
   localparam int CNT_W    = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_HOLD_FRAMES - 1);
   localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_HOLD_FRAMES - 1);

   GamePhase         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       winner_q, winner_d;
   logic             btn_prev_q, btn_prev_d;
   logic             play_en_q, play_en_d;
   logic             round_reset_q, round_reset_d;
   ObjectID          bg_q, bg_d, cap_q, cap_d;
   logic             cap_valid_q, cap_valid_d;

   logic                press, load, play;
   logic                p1_dead, p2_dead;
   logic [HP_WIDTH-1:0] p1_hp_next, p2_hp_next;

   assign press   = i_start_btn && !btn_prev_q;
   assign load    = (state_q == PHASE_IDLE) && press;
   assign play    = (state_q == PHASE_PLAY);
   assign p1_dead = (p1_hp_next == '0);
   assign p2_dead = (p2_hp_next == '0);

   hp_tracker #(.HP_INIT_VAL(HP_INIT), .COOLDOWN_FRMS(HIT_COOLDOWN_FRAMES)) u_p1 (
      .clk(i_clk), .rst(i_rst), .load(load), .en(play), .hit(i_p1_hit),
      .shield(i_p1_shield), .frame_tick(i_frame_tick),
      .hp(o_p1_hp), .hp_next(p1_hp_next)
   );

   hp_tracker #(.HP_INIT_VAL(HP_INIT), .COOLDOWN_FRMS(HIT_COOLDOWN_FRAMES)) u_p2 (
      .clk(i_clk), .rst(i_rst), .load(load), .en(play), .hit(i_p2_hit),
      .shield(i_p2_shield), .frame_tick(i_frame_tick),
      .hp(o_p2_hp), .hp_next(p2_hp_next)
   );

   always_comb begin
      state_d       = state_q;
      winner_d      = winner_q;
      btn_prev_d    = i_start_btn;
      round_reset_d = load;
      unique case (state_q)
         PHASE_IDLE: if (load) begin
            state_d  = PHASE_START;
            winner_d = 2'b00;
         end
         PHASE_START:
            if (i_frame_tick && (cnt_q == START_LAST)) state_d = PHASE_PLAY;
         PHASE_PLAY: if (p1_dead || p2_dead) begin
            state_d  = PHASE_RESULT;
            winner_d = {p1_dead, p2_dead};   // the surviving side wins; both dead is a draw
         end
         PHASE_RESULT:
            if (i_frame_tick && (cnt_q == RESULT_LAST)) state_d = PHASE_IDLE;
         default: state_d = PHASE_IDLE;
      endcase

      cnt_d = cnt_q;
      if (state_d != state_q) cnt_d = '0;
      else if (i_frame_tick)  cnt_d = cnt_q + 1'b1;

      play_en_d   = (state_d == PHASE_PLAY);
      bg_d        = OBJECT_MAP;
      cap_d       = OBJECT_MAP;
      cap_valid_d = 1'b0;
      unique case (state_d)
         PHASE_IDLE:  bg_d = OBJECT_IDLE_BG;
         PHASE_START: begin
            bg_d        = OBJECT_START_BG;
            cap_d       = OBJECT_START_CAPTION;
            cap_valid_d = 1'b1;
         end
         PHASE_RESULT: begin
            cap_d       = (winner_d == 2'b01) ? OBJECT_WIN_CAPTION : OBJECT_LOSE_CAPTION;
            cap_valid_d = 1'b1;
         end
         default: bg_d = OBJECT_MAP;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= PHASE_IDLE;
         cnt_q         <= '0;
         winner_q      <= 2'b00;
         btn_prev_q    <= 1'b1;
         play_en_q     <= 1'b0;
         round_reset_q <= 1'b0;
         bg_q          <= OBJECT_IDLE_BG;
         cap_q         <= OBJECT_MAP;
         cap_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         winner_q      <= winner_d;
         btn_prev_q    <= btn_prev_d;
         play_en_q     <= play_en_d;
         round_reset_q <= round_reset_d;
         bg_q          <= bg_d;
         cap_q         <= cap_d;
         cap_valid_q   <= cap_valid_d;
      end
   end

   assign o_phase          = state_q;
   assign o_winner         = winner_q;
   assign o_play_en        = play_en_q;
   assign o_round_reset    = round_reset_q;
   assign o_bg_object      = bg_q;
   assign o_caption_object = cap_q;
   assign o_caption_valid  = cap_valid_q;

endmodule
